icache_refill_ctrl: RTL and testbench

ICACHE_REFILL_CTRL -- requirements
Module: icache_refill_ctrl

---
 rtl/icache_refill_pkg.sv | 31 +++
 rtl/icache_refill_slot.sv | 104 ++++++++++
 rtl/icache_refill_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_icache_refill_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_refill_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : icache_refill_pkg
//  Brief    : Shared types and helpers for the instruction-cache refill
//             controller (slot states, refill type encoding, beat count).
//  Revision : 1.0 - initial release
// ============================================================================
package icache_refill_pkg;

   // Lifecycle of one outstanding-refill slot
   typedef enum logic [1:0] {
      FREE      = 2'd0,
      REQ       = 2'd1,
      WAIT_DATA = 2'd2,
      DONE      = 2'd3
   } slot_state_e;

   // Encoding of refill_type_o
   typedef enum logic {
      LINE   = 1'b0,
      SINGLE = 1'b1
   } refill_type_e;

   // Number of read beats needed to fill one cache line
   function automatic int unsigned refill_beats(input int unsigned line_width,
                                                input int unsigned data_width);
      return line_width / data_width;
   endfunction

endpackage
`default_nettype wire

// File: rtl/icache_refill_slot.sv
`default_nettype none
// ============================================================================
//  Module   : icache_refill_slot
//  Brief    : One outstanding refill: state, beat counter, captured address
//             and the line buffer being assembled from read beats.
//  Revision : 1.0 - initial release
// ============================================================================
module icache_refill_slot
   import icache_refill_pkg::*;
#(
   parameter int unsigned FETCH_ADDR_WIDTH = 56,
   parameter int unsigned AXI_DATA_WIDTH   = 64,
   parameter int unsigned LINE_WIDTH       = 128
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        alloc_i,
   input  logic [FETCH_ADDR_WIDTH-1:0] alloc_addr_i,
   input  logic                        alloc_bypass_i,
   input  logic                        req_gnt_i,
   input  logic                        beat_i,
   input  logic                        beat_last_i,
   input  logic [AXI_DATA_WIDTH-1:0]   beat_data_i,
   input  logic                        flush_i,
   input  logic                        release_i,
   output slot_state_e                 state_o,
   output logic [FETCH_ADDR_WIDTH-1:0] addr_o,
   output logic                        bypass_o,
   output logic [LINE_WIDTH-1:0]       data_o,
   output logic                        beat_err_o
);

   localparam int unsigned BEATS          = refill_beats(LINE_WIDTH, AXI_DATA_WIDTH);
   localparam int unsigned BEAT_CNT_WIDTH = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [BEAT_CNT_WIDTH-1:0] c_last_beat = BEAT_CNT_WIDTH'(BEATS - 1);

   slot_state_e                              r_state;
   slot_state_e                              w_state_nxt;
   logic [BEAT_CNT_WIDTH-1:0]                r_beat;
   logic [BEATS-1:0][AXI_DATA_WIDTH-1:0]     r_data;
   logic [FETCH_ADDR_WIDTH-1:0]              r_addr;
   logic                                     r_bypass;
   logic                                     w_exp_last;
   logic                                     w_mismatch;
   logic                                     w_accept;

   // State register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= FREE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state: a beat that closes or breaks the burst both end in DONE
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         FREE:      if (alloc_i) w_state_nxt = REQ;
         REQ: begin
            // A grant landing in the flush cycle still wins: data will arrive
            if (req_gnt_i)    w_state_nxt = WAIT_DATA;
            else if (flush_i) w_state_nxt = FREE;
         end
         WAIT_DATA: if (beat_i && (beat_last_i || w_exp_last)) w_state_nxt = DONE;
         DONE:      if (release_i) w_state_nxt = FREE;
         default:   w_state_nxt = FREE;
      endcase
   end

   // Outputs: beat acceptance and protocol-mismatch flag
   always_comb begin
      w_exp_last = r_bypass | (r_beat == c_last_beat);
      w_mismatch = (beat_last_i != w_exp_last);
      w_accept   = beat_i & ~w_mismatch;
      beat_err_o = beat_i & w_mismatch;
   end

   // Datapath: capture address on allocation, assemble the line beat by beat
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_beat   <= '0;
         r_data   <= '0;
         r_addr   <= '0;
         r_bypass <= 1'b0;
      end else if (alloc_i) begin
         r_beat   <= '0;
         r_data   <= '0;
         r_addr   <= alloc_addr_i;
         r_bypass <= alloc_bypass_i;
      end else if (w_accept) begin
         r_data[r_beat] <= beat_data_i;
         r_beat         <= r_beat + 1'b1;
      end
   end

   assign state_o  = r_state;
   assign addr_o   = r_addr;
   assign bypass_o = r_bypass;
   assign data_o   = r_data;

endmodule
`default_nettype wire

// File: rtl/icache_refill_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : icache_refill_ctrl
//  Brief    : Instruction-cache refill controller. Accepts misses into a
//             small pool of slots, issues refill requests oldest-first,
//             reassembles (possibly interleaved) read beats per ID and
//             delivers completed lines one per cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module icache_refill_ctrl
   import icache_refill_pkg::*;
#(
   parameter int unsigned FETCH_ADDR_WIDTH = 56,
   parameter int unsigned AXI_DATA_WIDTH   = 64,
   parameter int unsigned LINE_WIDTH       = 128,
   parameter int unsigned ID_WIDTH         = 4,
   parameter int unsigned NUM_SLOTS        = 2
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        miss_req_i,
   input  logic [FETCH_ADDR_WIDTH-1:0] miss_addr_i,
   input  logic                        miss_bypass_i,
   output logic                        miss_gnt_o,
   output logic                        refill_req_o,
   output logic                        refill_type_o,
   output logic [FETCH_ADDR_WIDTH-1:0] refill_addr_o,
   output logic [ID_WIDTH-1:0]         refill_ID_o,
   input  logic                        refill_gnt_i,
   input  logic                        refill_r_valid_i,
   input  logic                        refill_r_last_i,
   input  logic [AXI_DATA_WIDTH-1:0]   refill_r_rdata_i,
   input  logic [ID_WIDTH-1:0]         refill_r_ID_i,
   output logic                        line_valid_o,
   output logic [FETCH_ADDR_WIDTH-1:0] line_addr_o,
   output logic [LINE_WIDTH-1:0]       line_data_o,
   output logic                        line_bypass_o,
   input  logic                        flush_i,
   output logic                        flushed_o,
   output logic                        err_o
);

   localparam int unsigned IDX_WIDTH = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
   localparam int unsigned CNT_WIDTH = $clog2(NUM_SLOTS + 1);
   localparam logic [FETCH_ADDR_WIDTH-1:0] c_line_mask =
      ~FETCH_ADDR_WIDTH'(LINE_WIDTH / 8 - 1);
   localparam logic [FETCH_ADDR_WIDTH-1:0] c_beat_mask =
      ~FETCH_ADDR_WIDTH'(AXI_DATA_WIDTH / 8 - 1);

   // Per-slot views
   slot_state_e                 w_state     [NUM_SLOTS];
   logic [FETCH_ADDR_WIDTH-1:0] w_slot_addr [NUM_SLOTS];
   logic [LINE_WIDTH-1:0]       w_slot_data [NUM_SLOTS];
   logic [NUM_SLOTS-1:0]        w_slot_bypass;
   logic [NUM_SLOTS-1:0]        w_alloc;
   logic [NUM_SLOTS-1:0]        w_req_gnt;
   logic [NUM_SLOTS-1:0]        w_beat_hit;
   logic [NUM_SLOTS-1:0]        w_beat_err;
   logic [NUM_SLOTS-1:0]        w_release;

   // Slot scan results
   logic                        w_free_any;
   logic                        w_all_free;
   logic                        w_done_any;
   logic [IDX_WIDTH-1:0]        w_alloc_idx;
   logic [IDX_WIDTH-1:0]        w_done_idx;
   logic [FETCH_ADDR_WIDTH-1:0] w_miss_addr_aligned;
   logic                        w_line_valid;

   // Allocation-order queue of slots waiting in REQ; entry 0 is presented
   logic [NUM_SLOTS-1:0][IDX_WIDTH-1:0] r_order;
   logic [NUM_SLOTS-1:0][IDX_WIDTH-1:0] w_order_nxt;
   logic [CNT_WIDTH-1:0]                r_cnt;
   logic [CNT_WIDTH-1:0]                w_cnt_mid;
   logic [CNT_WIDTH-1:0]                w_cnt_nxt;
   logic                                w_pop;
   logic                                w_head_new;
   logic [IDX_WIDTH-1:0]                w_head_nxt;
   logic                                w_head_bypass;

   // Registered refill request and error flag
   logic                        r_refill_req;
   refill_type_e                r_refill_type;
   logic [FETCH_ADDR_WIDTH-1:0] r_refill_addr;
   logic [ID_WIDTH-1:0]         r_refill_id;
   logic                        r_err;

   assign miss_gnt_o          = miss_req_i & w_free_any & ~flush_i & ~rst_i;
   assign w_miss_addr_aligned = miss_addr_i & (miss_bypass_i ? c_beat_mask : c_line_mask);

   // Find lowest FREE slot (allocation target) and lowest DONE slot (delivery)
   always_comb begin
      w_free_any  = 1'b0;
      w_all_free  = 1'b1;
      w_done_any  = 1'b0;
      w_alloc_idx = '0;
      w_done_idx  = '0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (w_state[i] == FREE) begin
            w_free_any  = 1'b1;
            w_alloc_idx = IDX_WIDTH'(i);
         end else begin
            w_all_free  = 1'b0;
         end
         if (w_state[i] == DONE) begin
            w_done_any = 1'b1;
            w_done_idx = IDX_WIDTH'(i);
         end
      end
   end

   for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
      assign w_alloc[i]    = miss_gnt_o & (w_alloc_idx == IDX_WIDTH'(i));
      assign w_req_gnt[i]  = r_refill_req & refill_gnt_i & (r_refill_id == ID_WIDTH'(i));
      assign w_beat_hit[i] = refill_r_valid_i & (refill_r_ID_i == ID_WIDTH'(i))
                             & (w_state[i] == WAIT_DATA);
      // DONE slots are drained one per cycle, or all at once under flush
      assign w_release[i]  = (w_state[i] == DONE)
                             & (flush_i | (w_done_idx == IDX_WIDTH'(i)));

      icache_refill_slot #(
         .FETCH_ADDR_WIDTH (FETCH_ADDR_WIDTH),
         .AXI_DATA_WIDTH   (AXI_DATA_WIDTH),
         .LINE_WIDTH       (LINE_WIDTH)
      ) u_slot (
         .clk_i          (clk_i),
         .rst_i          (rst_i),
         .alloc_i        (w_alloc[i]),
         .alloc_addr_i   (w_miss_addr_aligned),
         .alloc_bypass_i (miss_bypass_i),
         .req_gnt_i      (w_req_gnt[i]),
         .beat_i         (w_beat_hit[i]),
         .beat_last_i    (refill_r_last_i),
         .beat_data_i    (refill_r_rdata_i),
         .flush_i        (flush_i),
         .release_i      (w_release[i]),
         .state_o        (w_state[i]),
         .addr_o         (w_slot_addr[i]),
         .bypass_o       (w_slot_bypass[i]),
         .data_o         (w_slot_data[i]),
         .beat_err_o     (w_beat_err[i])
      );
   end

   // Next contents of the REQ queue: pop on grant, drop all on flush, push on miss grant
   always_comb begin
      w_pop       = r_refill_req & refill_gnt_i;
      w_order_nxt = r_order;
      w_cnt_mid   = r_cnt;
      if (w_pop) begin
         for (int i = 0; i < NUM_SLOTS - 1; i++) begin
            w_order_nxt[i] = r_order[i+1];
         end
         w_cnt_mid = r_cnt - 1'b1;
      end
      if (flush_i) begin
         w_cnt_mid = '0;
      end
      w_cnt_nxt  = w_cnt_mid;
      // A miss landing in an empty queue becomes the head before its slot
      // has captured the address, so take address/type straight from the miss
      w_head_new = miss_gnt_o & (w_cnt_mid == '0);
      if (miss_gnt_o) begin
         for (int i = 0; i < NUM_SLOTS; i++) begin
            if (w_cnt_mid == CNT_WIDTH'(i)) begin
               w_order_nxt[i] = w_alloc_idx;
            end
         end
         w_cnt_nxt = w_cnt_mid + 1'b1;
      end
      w_head_nxt    = w_order_nxt[0];
      w_head_bypass = w_head_new ? miss_bypass_i : w_slot_bypass[w_head_nxt];
   end

   // Queue and registered refill request; stable until accepted
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_order       <= '0;
         r_cnt         <= '0;
         r_refill_req  <= 1'b0;
         r_refill_type <= LINE;
         r_refill_addr <= '0;
         r_refill_id   <= '0;
      end else begin
         r_order       <= w_order_nxt;
         r_cnt         <= w_cnt_nxt;
         r_refill_req  <= (w_cnt_nxt != '0);
         r_refill_type <= w_head_bypass ? SINGLE : LINE;
         r_refill_addr <= w_head_new ? w_miss_addr_aligned : w_slot_addr[w_head_nxt];
         r_refill_id   <= ID_WIDTH'(w_head_nxt);
      end
   end

   // Sticky error: orphan beats or beats whose last flag disagrees with the count
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_err <= 1'b0;
      end else if ((refill_r_valid_i && (w_beat_hit == '0)) || (w_beat_err != '0)) begin
         r_err <= 1'b1;
      end
   end

   // Delivery port: lowest DONE slot, suppressed under flush, zero when idle
   always_comb begin
      w_line_valid  = w_done_any & ~flush_i;
      line_addr_o   = '0;
      line_data_o   = '0;
      line_bypass_o = 1'b0;
      if (w_line_valid) begin
         line_addr_o   = w_slot_addr[w_done_idx];
         line_data_o   = w_slot_data[w_done_idx];
         line_bypass_o = w_slot_bypass[w_done_idx];
      end
   end

   assign line_valid_o  = w_line_valid;
   assign refill_req_o  = r_refill_req;
   assign refill_type_o = r_refill_type;
   assign refill_addr_o = r_refill_addr;
   assign refill_ID_o   = r_refill_id;
   assign flushed_o     = w_all_free;
   assign err_o         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_icache_refill_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_icache_refill_ctrl
//  Brief    : Directed self-checking bench for icache_refill_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_icache_refill_ctrl;

   localparam int FA = 56;
   localparam int AD = 64;
   localparam int LW = 128;
   localparam int IW = 4;
   localparam int NS = 2;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          miss_req_i;
   logic [FA-1:0] miss_addr_i;
   logic          miss_bypass_i;
   logic          miss_gnt_o;
   logic          refill_req_o;
   logic          refill_type_o;
   logic [FA-1:0] refill_addr_o;
   logic [IW-1:0] refill_ID_o;
   logic          refill_gnt_i;
   logic          refill_r_valid_i;
   logic          refill_r_last_i;
   logic [AD-1:0] refill_r_rdata_i;
   logic [IW-1:0] refill_r_ID_i;
   logic          line_valid_o;
   logic [FA-1:0] line_addr_o;
   logic [LW-1:0] line_data_o;
   logic          line_bypass_o;
   logic          flush_i;
   logic          flushed_o;
   logic          err_o;

   int checks = 0;
   int errors = 0;

   always #5 clk_i = ~clk_i;

   icache_refill_ctrl #(
      .FETCH_ADDR_WIDTH (FA),
      .AXI_DATA_WIDTH   (AD),
      .LINE_WIDTH       (LW),
      .ID_WIDTH         (IW),
      .NUM_SLOTS        (NS)
   ) dut (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .miss_req_i       (miss_req_i),
      .miss_addr_i      (miss_addr_i),
      .miss_bypass_i    (miss_bypass_i),
      .miss_gnt_o       (miss_gnt_o),
      .refill_req_o     (refill_req_o),
      .refill_type_o    (refill_type_o),
      .refill_addr_o    (refill_addr_o),
      .refill_ID_o      (refill_ID_o),
      .refill_gnt_i     (refill_gnt_i),
      .refill_r_valid_i (refill_r_valid_i),
      .refill_r_last_i  (refill_r_last_i),
      .refill_r_rdata_i (refill_r_rdata_i),
      .refill_r_ID_i    (refill_r_ID_i),
      .line_valid_o     (line_valid_o),
      .line_addr_o      (line_addr_o),
      .line_data_o      (line_data_o),
      .line_bypass_o    (line_bypass_o),
      .flush_i          (flush_i),
      .flushed_o        (flushed_o),
      .err_o            (err_o)
   );

   // Advance to 1 time unit after the next rising edge
   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic miss(input logic [FA-1:0] addr, input logic byp);
      miss_req_i    = 1'b1;
      miss_addr_i   = addr;
      miss_bypass_i = byp;
      cyc();
      miss_req_i    = 1'b0;
      miss_bypass_i = 1'b0;
   endtask

   task automatic grant();
      refill_gnt_i = 1'b1;
      cyc();
      refill_gnt_i = 1'b0;
   endtask

   task automatic beat(input logic [IW-1:0] id, input logic [AD-1:0] data, input logic last);
      refill_r_valid_i = 1'b1;
      refill_r_ID_i    = id;
      refill_r_rdata_i = data;
      refill_r_last_i  = last;
      cyc();
      refill_r_valid_i = 1'b0;
      refill_r_last_i  = 1'b0;
   endtask

   task automatic test_reset();
      rst_i       = 1'b1;
      miss_req_i  = 1'b1;
      miss_addr_i = 56'h40;
      repeat (2) cyc();
      checks++; if (miss_gnt_o !== 1'b0) begin errors++; $display("FAIL reset_miss_gnt got %0b want 0", miss_gnt_o); end
      checks++; if (refill_req_o !== 1'b0) begin errors++; $display("FAIL reset_refill_req got %0b want 0", refill_req_o); end
      checks++; if (line_valid_o !== 1'b0) begin errors++; $display("FAIL reset_line_valid got %0b want 0", line_valid_o); end
      checks++; if (line_data_o !== '0) begin errors++; $display("FAIL reset_line_data got %h want 0", line_data_o); end
      checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err got %0b want 0", err_o); end
      checks++; if (flushed_o !== 1'b1) begin errors++; $display("FAIL reset_flushed got %0b want 1", flushed_o); end
      miss_req_i = 1'b0;
      rst_i      = 1'b0;
      cyc();
   endtask

   task automatic test_line();
      miss_req_i    = 1'b1;
      miss_addr_i   = 56'h60;
      miss_bypass_i = 1'b0;
      #4;
      checks++; if (miss_gnt_o !== 1'b1) begin errors++; $display("FAIL line_miss_gnt got %0b want 1", miss_gnt_o); end
      cyc();
      miss_req_i = 1'b0;
      checks++; if (refill_req_o !== 1'b1) begin errors++; $display("FAIL line_refill_req got %0b want 1", refill_req_o); end
      checks++; if (refill_addr_o !== 56'h60) begin errors++; $display("FAIL line_refill_addr got %h want 60", refill_addr_o); end
      checks++; if (refill_type_o !== 1'b0) begin errors++; $display("FAIL line_refill_type got %0b want 0", refill_type_o); end
      checks++; if (refill_ID_o !== 4'd0) begin errors++; $display("FAIL line_refill_id got %0d want 0", refill_ID_o); end
      grant();
      checks++; if (refill_req_o !== 1'b0) begin errors++; $display("FAIL line_req_drop got %0b want 0", refill_req_o); end
      beat(4'd0, 64'hfc, 1'b0);
      checks++; if (line_valid_o !== 1'b0) begin errors++; $display("FAIL line_early_valid got %0b want 0", line_valid_o); end
      beat(4'd0, 64'h132433d, 1'b1);
      checks++; if (line_valid_o !== 1'b1) begin errors++; $display("FAIL line_valid got %0b want 1", line_valid_o); end
      checks++; if (line_data_o !== 128'h000000000132433d_00000000000000fc) begin errors++; $display("FAIL line_data got %h want 000000000132433d00000000000000fc", line_data_o); end
      checks++; if (line_addr_o !== 56'h60) begin errors++; $display("FAIL line_addr got %h want 60", line_addr_o); end
      checks++; if (line_bypass_o !== 1'b0) begin errors++; $display("FAIL line_bypass got %0b want 0", line_bypass_o); end
      cyc();
      checks++; if (line_valid_o !== 1'b0) begin errors++; $display("FAIL line_pulse got %0b want 0", line_valid_o); end
      checks++; if (flushed_o !== 1'b1) begin errors++; $display("FAIL line_flushed got %0b want 1", flushed_o); end
   endtask

   task automatic test_bypass();
      miss(56'h68, 1'b1);
      checks++; if (refill_type_o !== 1'b1) begin errors++; $display("FAIL byp_type got %0b want 1", refill_type_o); end
      checks++; if (refill_addr_o !== 56'h68) begin errors++; $display("FAIL byp_addr got %h want 68", refill_addr_o); end
      grant();
      beat(4'd0, 64'h93949, 1'b1);
      checks++; if (line_valid_o !== 1'b1) begin errors++; $display("FAIL byp_valid got %0b want 1", line_valid_o); end
      checks++; if (line_data_o !== 128'h93949) begin errors++; $display("FAIL byp_data got %h want 93949", line_data_o); end
      checks++; if (line_bypass_o !== 1'b1) begin errors++; $display("FAIL byp_flag got %0b want 1", line_bypass_o); end
      checks++; if (line_addr_o !== 56'h68) begin errors++; $display("FAIL byp_line_addr got %h want 68", line_addr_o); end
      cyc();
   endtask

   task automatic test_out_of_order();
      miss(56'h10c, 1'b0);
      checks++; if (refill_addr_o !== 56'h100) begin errors++; $display("FAIL ooo_align got %h want 100", refill_addr_o); end
      miss(56'h200, 1'b0);
      checks++; if (refill_ID_o !== 4'd0) begin errors++; $display("FAIL ooo_oldest_id got %0d want 0", refill_ID_o); end
      miss_req_i  = 1'b1;
      miss_addr_i = 56'h300;
      #4;
      checks++; if (miss_gnt_o !== 1'b0) begin errors++; $display("FAIL ooo_full_gnt got %0b want 0", miss_gnt_o); end
      miss_req_i = 1'b0;
      grant();
      checks++; if (refill_ID_o !== 4'd1) begin errors++; $display("FAIL ooo_second_id got %0d want 1", refill_ID_o); end
      checks++; if (refill_addr_o !== 56'h200) begin errors++; $display("FAIL ooo_second_addr got %h want 200", refill_addr_o); end
      grant();
      beat(4'd0, 64'haaaa0000aaaa0000, 1'b0);
      beat(4'd1, 64'hbbbb0000bbbb0000, 1'b0);
      beat(4'd1, 64'hbbbb1111bbbb1111, 1'b1);
      checks++; if (line_valid_o !== 1'b1 || line_addr_o !== 56'h200) begin errors++; $display("FAIL ooo_first got valid %0b addr %h want 1 200", line_valid_o, line_addr_o); end
      checks++; if (line_data_o !== 128'hbbbb1111bbbb1111_bbbb0000bbbb0000) begin errors++; $display("FAIL ooo_first_data got %h want bbbb1111bbbb1111bbbb0000bbbb0000", line_data_o); end
      beat(4'd0, 64'haaaa1111aaaa1111, 1'b1);
      checks++; if (line_valid_o !== 1'b1 || line_addr_o !== 56'h100) begin errors++; $display("FAIL ooo_second got valid %0b addr %h want 1 100", line_valid_o, line_addr_o); end
      checks++; if (line_data_o !== 128'haaaa1111aaaa1111_aaaa0000aaaa0000) begin errors++; $display("FAIL ooo_second_data got %h want aaaa1111aaaa1111aaaa0000aaaa0000", line_data_o); end
      checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL ooo_err got %0b want 0", err_o); end
      cyc();
      checks++; if (flushed_o !== 1'b1) begin errors++; $display("FAIL ooo_flushed got %0b want 1", flushed_o); end
   endtask

   task automatic test_orphan_beat();
      beat(4'd3, 64'h1234, 1'b1);
      checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL orphan_err got %0b want 1", err_o); end
      checks++; if (line_valid_o !== 1'b0) begin errors++; $display("FAIL orphan_valid got %0b want 0", line_valid_o); end
      repeat (2) cyc();
      checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL orphan_sticky got %0b want 1", err_o); end
   endtask

   task automatic test_flush();
      miss(56'h300, 1'b0);
      grant();
      miss(56'h400, 1'b0);
      checks++; if (refill_req_o !== 1'b1 || refill_ID_o !== 4'd1) begin errors++; $display("FAIL flush_pre_req got %0b id %0d want 1 1", refill_req_o, refill_ID_o); end
      beat(4'd0, 64'hc0, 1'b0);
      flush_i          = 1'b1;
      miss_req_i       = 1'b1;
      miss_addr_i      = 56'h500;
      refill_r_valid_i = 1'b1;
      refill_r_ID_i    = 4'd0;
      refill_r_rdata_i = 64'hc1;
      refill_r_last_i  = 1'b1;
      #4;
      checks++; if (miss_gnt_o !== 1'b0) begin errors++; $display("FAIL flush_gnt got %0b want 0", miss_gnt_o); end
      @(posedge clk_i);
      #1;
      refill_r_valid_i = 1'b0;
      refill_r_last_i  = 1'b0;
      checks++; if (line_valid_o !== 1'b0) begin errors++; $display("FAIL flush_valid got %0b want 0", line_valid_o); end
      checks++; if (refill_req_o !== 1'b0) begin errors++; $display("FAIL flush_req got %0b want 0", refill_req_o); end
      checks++; if (flushed_o !== 1'b0) begin errors++; $display("FAIL flush_busy got %0b want 0", flushed_o); end
      cyc();
      checks++; if (flushed_o !== 1'b1) begin errors++; $display("FAIL flush_done got %0b want 1", flushed_o); end
      checks++; if (line_valid_o !== 1'b0) begin errors++; $display("FAIL flush_valid2 got %0b want 0", line_valid_o); end
      flush_i    = 1'b0;
      miss_req_i = 1'b0;
      cyc();
   endtask

   task automatic test_reset_mid_burst();
      miss(56'h500, 1'b0);
      grant();
      miss(56'h600, 1'b0);
      beat(4'd0, 64'hd0, 1'b0);
      miss_req_i  = 1'b1;
      miss_addr_i = 56'h700;
      rst_i       = 1'b1;
      #1;
      checks++; if (refill_req_o !== 1'b0) begin errors++; $display("FAIL rst_mid_req got %0b want 0", refill_req_o); end
      checks++; if (miss_gnt_o !== 1'b0) begin errors++; $display("FAIL rst_mid_gnt got %0b want 0", miss_gnt_o); end
      checks++; if (flushed_o !== 1'b1) begin errors++; $display("FAIL rst_mid_flushed got %0b want 1", flushed_o); end
      checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL rst_mid_err got %0b want 0", err_o); end
      checks++; if (line_valid_o !== 1'b0 || line_addr_o !== '0) begin errors++; $display("FAIL rst_mid_line got valid %0b addr %h want 0 0", line_valid_o, line_addr_o); end
      cyc();
      rst_i      = 1'b0;
      miss_req_i = 1'b0;
      cyc();
      beat(4'd0, 64'hd1, 1'b1);
      checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL rst_stale_err got %0b want 1", err_o); end
      checks++; if (line_valid_o !== 1'b0) begin errors++; $display("FAIL rst_stale_valid got %0b want 0", line_valid_o); end
   endtask

   initial begin
      rst_i            = 1'b1;
      miss_req_i       = 1'b0;
      miss_addr_i      = '0;
      miss_bypass_i    = 1'b0;
      refill_gnt_i     = 1'b0;
      refill_r_valid_i = 1'b0;
      refill_r_last_i  = 1'b0;
      refill_r_rdata_i = '0;
      refill_r_ID_i    = '0;
      flush_i          = 1'b0;
      #1;
      test_reset();
      test_line();
      test_bypass();
      test_out_of_order();
      test_orphan_beat();
      test_flush();
      test_reset_mid_burst();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
